// File: rtl/data_sram_responder_pkg.sv
// data_sram_responder shared types.
// Size codes, queued request entry, byte-mask helper.
package data_sram_responder_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  localparam int REQ_W = $bits(req_t);

  function automatic logic [31:0] strb_mask(
    input logic [3:0] s
  );
    return {{8{s[3]}}, {8{s[2]}},
            {8{s[1]}}, {8{s[0]}}};
  endfunction

endpackage

// File: rtl/data_sram_responder_if.sv
// data_sram req/addr_ok/data_ok bundle.
// master = requester (execute stage), slave = responder.
interface data_sram_responder_if;
  import data_sram_responder_pkg::*;

  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_req,
    output data_sram_wr,
    output data_sram_size,
    output data_sram_wstrb,
    output data_sram_addr,
    output data_sram_wdata,
    input  data_sram_addr_ok,
    input  data_sram_data_ok,
    input  data_sram_rdata
  );

  modport slave (
    input  data_sram_req,
    input  data_sram_wr,
    input  data_sram_size,
    input  data_sram_wstrb,
    input  data_sram_addr,
    input  data_sram_wdata,
    output data_sram_addr_ok,
    output data_sram_data_ok,
    output data_sram_rdata
  );

endinterface

// File: rtl/data_sram_responder_req_queue.sv
// In-order request FIFO for data_sram_responder.
// Ports: clk, reset, push_i, pop_i, din_i -> head_o, count_o.
module data_sram_responder_req_queue
  import data_sram_responder_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  req_t          din_i,
  output req_t          head_o,
  output logic [CW-1:0] count_o
);

  localparam int PW =
    (DEPTH > 1) ? $clog2(DEPTH) : 1;

  req_t          buf_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ?
      '0 : p + PW'(1);
  endfunction

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (push_i) wr_d = inc(wr_q);
    if (pop_i)  rd_d = inc(rd_q);
    unique case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Payload storage needs no reset:
  // only entries below count are observed.
  always_ff @(posedge clk) begin
    if (push_i) buf_q[wr_q] <= din_i;
  end

  assign head_o  = buf_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/data_sram_responder.sv
// SRAM-like data-port responder with latency.
// Ports: clk, reset, dsram (slave): req in, addr_ok/data_ok/rdata out.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int LATENCY = 2,
  parameter int AW      = 12
) (
  input  logic             clk,
  input  logic             reset,
  data_sram_responder_if.slave dsram
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int LW =
    (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

  req_t          push_ent;
  req_t          head;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic          addr_ok;
  logic          data_ok;
  logic [LW-1:0] lat_q, lat_d;
  logic [AW-1:0] widx;
  logic [31:0]   wmask;
  logic [31:0]   mem_q [2**AW];

  assign addr_ok =
    dsram.data_sram_req && (count < CW'(DEPTH));
  assign push = dsram.data_sram_req && addr_ok;

  assign push_ent = {
    dsram.data_sram_wr,
    dsram.data_sram_size,
    dsram.data_sram_wstrb,
    dsram.data_sram_addr,
    dsram.data_sram_wdata
  };

  data_sram_responder_req_queue #(
    .DEPTH(DEPTH)
  ) u_q (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (push_ent),
    .head_o  (head),
    .count_o (count)
  );

  // Head retires on every response.
  assign data_ok = (count != '0) && (lat_q == '0);
  assign pop     = data_ok;

  // Reload while idle or on retire, so each
  // new head sees the full wait.
  always_comb begin
    lat_d = lat_q;
    if ((count == '0) || pop)
      lat_d = LW'(LATENCY);
    else if (lat_q != '0)
      lat_d = lat_q - LW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lat_q <= LW'(LATENCY);
    else       lat_q <= lat_d;
  end

  // Word index wraps; byte offset ignored.
  assign widx  = head.addr[AW+1:2];
  assign wmask = strb_mask(head.wstrb);

  // Array survives reset.
  always_ff @(posedge clk) begin
    if (pop && head.wr)
      mem_q[widx] <= (mem_q[widx] & ~wmask) |
                     (head.wdata & wmask);
  end

  assign dsram.data_sram_addr_ok = addr_ok;
  assign dsram.data_sram_data_ok = data_ok;
  assign dsram.data_sram_rdata =
    (data_ok && !head.wr) ? mem_q[widx] : '0;

  logic unused_bits;
  assign unused_bits = ^{head.size,
                         head.addr[31:AW+2],
                         head.addr[1:0]};

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder.
// Two instances: DEPTH=2/LATENCY=2 and DEPTH=4/LATENCY=0.
module tb_data_sram_responder;
  import data_sram_responder_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  data_sram_responder_if ifa ();
  data_sram_responder_if ifb ();

  data_sram_responder #(
    .DEPTH(2), .LATENCY(2), .AW(12)
  ) dut_a (
    .clk(clk), .reset(reset), .dsram(ifa.slave)
  );

  data_sram_responder #(
    .DEPTH(4), .LATENCY(0), .AW(12)
  ) dut_b (
    .clk(clk), .reset(reset), .dsram(ifb.slave)
  );

  logic [31:0] bv [4] = '{32'hA0A0A001,
    32'h0B0B0B02, 32'hC3C3C3C3, 32'h44D4D4D4};

  task automatic chk(input string tag,
    input logic [31:0] obs,
    input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic a_set(input logic wr,
    input logic [31:0] addr,
    input logic [3:0] st,
    input logic [31:0] wd);
    ifa.data_sram_req   = 1'b1;
    ifa.data_sram_wr    = wr;
    ifa.data_sram_size  = SZ_WORD;
    ifa.data_sram_wstrb = st;
    ifa.data_sram_addr  = addr;
    ifa.data_sram_wdata = wd;
  endtask

  // Called at a negedge; returns at the negedge
  // after the accepting edge.
  task automatic a_issue(input logic wr,
    input logic [31:0] addr,
    input logic [3:0] st,
    input logic [31:0] wd);
    a_set(wr, addr, st, wd);
    for (int i = 0; i < 20; i++) begin
      #1;
      if (ifa.data_sram_addr_ok) begin
        @(posedge clk);
        @(negedge clk);
        ifa.data_sram_req = 1'b0;
        return;
      end
      @(negedge clk);
    end
    ifa.data_sram_req = 1'b0;
    chk("issue_timeout", 32'd0, 32'd1);
  endtask

  task automatic a_resp(input string tag,
    input logic [31:0] exp);
    for (int i = 0; i < 30; i++) begin
      if (ifa.data_sram_data_ok) begin
        chk(tag, ifa.data_sram_rdata, exp);
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic a_write(input logic [31:0] addr,
    input logic [3:0] st,
    input logic [31:0] wd);
    a_issue(1'b1, addr, st, wd);
    a_resp("wr_resp", 32'd0);
  endtask

  task automatic a_read(input string tag,
    input logic [31:0] addr,
    input logic [31:0] exp);
    a_issue(1'b0, addr, 4'h0, 32'd0);
    a_resp(tag, exp);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    ifa.data_sram_req   = 1'b0;
    ifa.data_sram_wr    = 1'b0;
    ifa.data_sram_size  = SZ_BYTE;
    ifa.data_sram_wstrb = 4'h0;
    ifa.data_sram_addr  = 32'd0;
    ifa.data_sram_wdata = 32'd0;
    ifb.data_sram_req   = 1'b0;
    ifb.data_sram_wr    = 1'b0;
    ifb.data_sram_size  = SZ_BYTE;
    ifb.data_sram_wstrb = 4'h0;
    ifb.data_sram_addr  = 32'd0;
    ifb.data_sram_wdata = 32'd0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_dok_a", ifa.data_sram_data_ok, 0);
    chk("rst_rdata_a", ifa.data_sram_rdata, 0);
    chk("rst_dok_b", ifb.data_sram_data_ok, 0);
    reset = 1'b0;
    @(negedge clk);

    // addr_ok follows req combinationally
    ifa.data_sram_req = 1'b1;
    #1 chk("aok_req", ifa.data_sram_addr_ok, 1);
    ifa.data_sram_req = 1'b0;
    #1 chk("aok_idle", ifa.data_sram_addr_ok, 0);
    @(negedge clk);

    a_write(32'h10, 4'hF, 32'hDEADBEEF);
    a_write(32'h20, 4'hF, 32'h11223344);
    a_write(32'h30, 4'hF, 32'hCAFEF00D);

    // exact latency: accept at T, data_ok T+3
    a_set(1'b0, 32'h10, 4'h0, 32'd0);
    #1 chk("t1_aok", ifa.data_sram_addr_ok, 1);
    @(posedge clk);
    @(negedge clk);
    ifa.data_sram_req = 1'b0;
    chk("t1_c1_dok", ifa.data_sram_data_ok, 0);
    @(negedge clk);
    chk("t1_c2_dok", ifa.data_sram_data_ok, 0);
    chk("t1_c2_rd", ifa.data_sram_rdata, 0);
    @(negedge clk);
    chk("t1_c3_dok", ifa.data_sram_data_ok, 1);
    chk("t1_c3_rd", ifa.data_sram_rdata,
        32'hDEADBEEF);
    @(negedge clk);
    chk("t1_c4_dok", ifa.data_sram_data_ok, 0);
    chk("t1_c4_rd", ifa.data_sram_rdata, 0);

    // byte write then read behind it
    a_issue(1'b1, 32'h21, 4'b0010, 32'hABABABAB);
    a_issue(1'b0, 32'h20, 4'h0, 32'd0);
    a_resp("t2_wr", 32'd0);
    a_resp("t2_rd", 32'h1122AB44);

    // backpressure with DEPTH=2
    a_set(1'b0, 32'h10, 4'h0, 32'd0);
    #1 chk("t3_aok1", ifa.data_sram_addr_ok, 1);
    @(posedge clk);
    @(negedge clk);
    ifa.data_sram_addr = 32'h20;
    #1 chk("t3_aok2", ifa.data_sram_addr_ok, 1);
    @(posedge clk);
    @(negedge clk);
    ifa.data_sram_addr = 32'h30;
    #1 chk("t3_aok3_full", ifa.data_sram_addr_ok, 0);
    chk("t3_dok_early", ifa.data_sram_data_ok, 0);
    @(negedge clk);
    chk("t3_aok3_still", ifa.data_sram_addr_ok, 0);
    chk("t3_dok1", ifa.data_sram_data_ok, 1);
    chk("t3_rd1", ifa.data_sram_rdata, 32'hDEADBEEF);
    @(negedge clk);
    chk("t3_aok3_free", ifa.data_sram_addr_ok, 1);
    chk("t3_dok_gap", ifa.data_sram_data_ok, 0);
    @(posedge clk);
    @(negedge clk);
    ifa.data_sram_req = 1'b0;
    a_resp("t3_rd2", 32'h1122AB44);
    a_resp("t3_rd3", 32'hCAFEF00D);

    // empty strobe write changes nothing
    a_write(32'h30, 4'h0, 32'h12345678);
    a_read("t5_rd", 32'h30, 32'hCAFEF00D);
    // upper and low address bits ignored
    a_read("t5_wrap", 32'h4033, 32'hCAFEF00D);

    // reset discards pending writes
    a_write(32'h40, 4'hF, 32'h55667788);
    a_issue(1'b1, 32'h10, 4'hF, 32'hFFFFFFFF);
    a_issue(1'b1, 32'h20, 4'hF, 32'h00000000);
    reset = 1'b1;
    #1 chk("t6_rst_dok", ifa.data_sram_data_ok, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_no_dok", ifa.data_sram_data_ok, 0);
    end
    a_read("t6_rd40", 32'h40, 32'h55667788);
    a_read("t6_rd10", 32'h10, 32'hDEADBEEF);
    a_read("t6_rd20", 32'h20, 32'h1122AB44);

    // LATENCY=0: one response per cycle
    for (int i = 0; i < 4; i++) begin
      ifb.data_sram_req   = 1'b1;
      ifb.data_sram_wr    = 1'b1;
      ifb.data_sram_size  = SZ_WORD;
      ifb.data_sram_wstrb = 4'hF;
      ifb.data_sram_addr  = 32'(i * 4);
      ifb.data_sram_wdata = bv[i];
      #1 chk("b_wr_aok", ifb.data_sram_addr_ok, 1);
      @(posedge clk);
      @(negedge clk);
      chk("b_wr_dok", ifb.data_sram_data_ok, 1);
      chk("b_wr_rd", ifb.data_sram_rdata, 0);
    end
    ifb.data_sram_req = 1'b0;
    @(negedge clk);
    chk("b_idle_dok", ifb.data_sram_data_ok, 0);
    for (int i = 0; i < 4; i++) begin
      ifb.data_sram_req  = 1'b1;
      ifb.data_sram_wr   = 1'b0;
      ifb.data_sram_addr = 32'(i * 4);
      #1 chk("b_rd_aok", ifb.data_sram_addr_ok, 1);
      @(posedge clk);
      @(negedge clk);
      chk("b_rd_dok", ifb.data_sram_data_ok, 1);
      chk("b_rd_data", ifb.data_sram_rdata, bv[i]);
    end
    ifb.data_sram_req = 1'b0;
    @(negedge clk);
    chk("b_end_dok", ifb.data_sram_data_ok, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
